// File: rtl/decode_cycle.sv
// RV32I instruction-decode stage: control decode, 32x32 register file with
// write-through bypass, immediate generation and the ID/EX pipeline register.
module decode_cycle #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RDE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J
   } immSel_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];

   logic       regWrite;
   logic [1:0] resultSrc;
   logic       memWrite;
   logic       jump;
   logic       branch;
   logic       aluSrc;
   logic [1:0] aluOp;
   logic [2:0] aluControl;
   immSel_t    immSel;
   logic [XLEN-1:0] immExt;

   always_comb begin
      regWrite  = 1'b0;
      resultSrc = 2'b00;
      memWrite  = 1'b0;
      jump      = 1'b0;
      branch    = 1'b0;
      aluSrc    = 1'b0;
      aluOp     = 2'b00;
      immSel    = IMM_NONE;
      case (opcode)
         OP_LOAD: begin
            regWrite  = 1'b1;
            resultSrc = 2'b01;
            aluSrc    = 1'b1;
            immSel    = IMM_I;
         end
         OP_STORE: begin
            memWrite = 1'b1;
            aluSrc   = 1'b1;
            immSel   = IMM_S;
         end
         OP_RTYPE: begin
            regWrite = 1'b1;
            aluOp    = 2'b10;
         end
         OP_IALU: begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            immSel   = IMM_I;
            aluOp    = 2'b10;
         end
         OP_BRANCH: begin
            branch = 1'b1;
            immSel = IMM_B;
            aluOp  = 2'b01;
         end
         OP_JAL: begin
            regWrite  = 1'b1;
            jump      = 1'b1;
            resultSrc = 2'b10;
            immSel    = IMM_J;
         end
         default: ;
      endcase
   end

   // Bit 30 only selects sub for register-register ops; for I-ALU it is immediate data.
   always_comb begin
      aluControl = 3'b000;
      case (aluOp)
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  aluControl = (opcode == OP_RTYPE && InstrD[30]) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   always_comb begin
      immExt = '0;
      case (immSel)
         IMM_I: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMM_S: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J: immExt = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: immExt = '0;
      endcase
   end

   logic [XLEN-1:0] regFile [NREGS];

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      end else if (RegWriteW && RDW != 5'd0) begin
         regFile[RDW] <= ResultW;
      end
   end

   logic [4:0]      rsAddr [2];
   logic [XLEN-1:0] rdData [2];
   assign rsAddr[0] = InstrD[19:15];
   assign rsAddr[1] = InstrD[24:20];

   // Same-edge write-back is forwarded so the stage never captures a stale value.
   for (genvar gi = 0; gi < 2; gi++) begin : gReadPort
      assign rdData[gi] = (rsAddr[gi] == 5'd0) ? '0 :
                          (RegWriteW && RDW == rsAddr[gi]) ? ResultW :
                          regFile[rsAddr[gi]];
   end

   always_ff @(posedge clk) begin
      if (!rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RDE         <= 5'd0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= regWrite;
         ResultSrcE  <= resultSrc;
         MemWriteE   <= memWrite;
         JumpE       <= jump;
         BranchE     <= branch;
         ALUSrcE     <= aluSrc;
         ALUControlE <= aluControl;
         RD1E        <= rdData[0];
         RD2E        <= rdData[1];
         ImmExtE     <= immExt;
         RDE         <= InstrD[11:7];
         Rs1E        <= InstrD[19:15];
         Rs2E        <= InstrD[24:20];
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed and randomized checks of decode_cycle against a behavioural model
// of the decode rules and a shadow register file.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        FlushE;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  RDE, Rs1E, Rs2E;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RDE(RDE), .Rs1E(Rs1E),
      .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] regWrite, resultSrc, memWrite, jump, branch, aluSrc, aluCtl;
      logic [31:0] rd1, rd2, imm, rd, rs1, rs2, pc, pc4;
   } exp_t;

   logic [31:0] shadowRegs [32];
   int nAsserts = 0;
   int nFails   = 0;
   int cycNum   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAsserts++;
      assert (obs === expv) else begin
         nFails++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycNum, obs, expv);
      end
   endtask

   function automatic logic [31:0] readReg(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (RegWriteW && RDW == idx) return ResultW;
      return shadowRegs[idx];
   endfunction

   // Expected E-stage contents for the current D-stage inputs.
   function automatic exp_t model();
      exp_t e;
      int   s;
      logic [31:0] f3, b30, lo;
      e = '{default: 32'd0};
      if (!rst || FlushE) return e;
      s   = int'(InstrD);
      f3  = 32'(InstrD[14:12]);
      b30 = 32'(InstrD[30]);
      e.rd  = 32'(InstrD[11:7]);
      e.rs1 = 32'(InstrD[19:15]);
      e.rs2 = 32'(InstrD[24:20]);
      e.rd1 = readReg(InstrD[19:15]);
      e.rd2 = readReg(InstrD[24:20]);
      e.pc  = PCD;
      e.pc4 = PCPlus4D;
      case (InstrD[6:0])
         7'h03: begin e.regWrite = 1; e.resultSrc = 1; e.aluSrc = 1; e.imm = 32'(s >>> 20); end
         7'h23: begin
            e.memWrite = 1; e.aluSrc = 1;
            e.imm = 32'((s >>> 25) * 32) + 32'(InstrD[11:7]);
         end
         7'h33, 7'h13: begin
            e.regWrite = 1;
            if (InstrD[6:0] == 7'h13) begin e.aluSrc = 1; e.imm = 32'(s >>> 20); end
            if (f3 == 2) e.aluCtl = 5;
            else if (f3 == 6) e.aluCtl = 3;
            else if (f3 == 7) e.aluCtl = 2;
            else if (f3 == 0 && InstrD[6:0] == 7'h33 && b30 == 1) e.aluCtl = 1;
         end
         7'h63: begin
            e.branch = 1; e.aluCtl = 1;
            lo = 32'(InstrD[7]) * 2048 + 32'(InstrD[30:25]) * 32 + 32'(InstrD[11:8]) * 2;
            e.imm = 32'((s >>> 31) * 4096) + lo;
         end
         7'h6F: begin
            e.regWrite = 1; e.jump = 1; e.resultSrc = 2;
            lo = 32'(InstrD[19:12]) * 4096 + 32'(InstrD[20]) * 2048 + 32'(InstrD[30:21]) * 2;
            e.imm = 32'((s >>> 31) * 1048576) + lo;
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic tick();
      exp_t e;
      e = model();
      @(posedge clk);
      #1;
      cycNum++;
      if (!rst) begin
         for (int i = 0; i < 32; i++) shadowRegs[i] = 32'd0;
      end else if (RegWriteW && RDW != 0) begin
         shadowRegs[RDW] = ResultW;
      end
      check("RegWriteE",   32'(RegWriteE),   e.regWrite);
      check("ResultSrcE",  32'(ResultSrcE),  e.resultSrc);
      check("MemWriteE",   32'(MemWriteE),   e.memWrite);
      check("JumpE",       32'(JumpE),       e.jump);
      check("BranchE",     32'(BranchE),     e.branch);
      check("ALUSrcE",     32'(ALUSrcE),     e.aluSrc);
      check("ALUControlE", 32'(ALUControlE), e.aluCtl);
      check("RD1E",        RD1E,             e.rd1);
      check("RD2E",        RD2E,             e.rd2);
      check("ImmExtE",     ImmExtE,          e.imm);
      check("RDE",         32'(RDE),         e.rd);
      check("Rs1E",        32'(Rs1E),        e.rs1);
      check("Rs2E",        32'(Rs2E),        e.rs2);
      check("PCE",         PCE,              e.pc);
      check("PCPlus4E",    PCPlus4E,         e.pc4);
   endtask

   task automatic setW(input logic we, input logic [4:0] rd, input logic [31:0] data);
      RegWriteW = we;
      RDW       = rd;
      ResultW   = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0]  ops [7];
      logic [31:0] r;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37};
      for (int i = 0; i < 32; i++) shadowRegs[i] = 32'd0;
      rst = 1'b0; InstrD = 32'h002081B3; PCD = 32'h40; PCPlus4D = 32'h44;
      FlushE = 1'b0; setW(1'b0, 5'd0, 32'd0);
      tick(); tick();
      check("reset_RegWriteE", 32'(RegWriteE), 32'd0);

      rst = 1'b1; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0;
      setW(1'b1, 5'd1, 32'd5); tick();
      setW(1'b1, 5'd2, 32'd7); tick();
      setW(1'b0, 5'd0, 32'd0);
      InstrD = 32'h002081B3; PCD = 32'h10; PCPlus4D = 32'h14; tick();
      check("add_RD1E", RD1E, 32'd5);
      check("add_RD2E", RD2E, 32'd7);
      check("add_RDE", 32'(RDE), 32'd3);
      check("add_RegWriteE", 32'(RegWriteE), 32'd1);
      check("add_PCPlus4E", PCPlus4E, 32'h14);

      InstrD = 32'hFFC12283; tick();
      check("lw_ImmExtE", ImmExtE, 32'hFFFFFFFC);
      check("lw_ResultSrcE", 32'(ResultSrcE), 32'd1);
      InstrD = 32'hFE208CE3; tick();
      check("beq_ImmExtE", ImmExtE, 32'hFFFFFFF8);
      check("beq_ALUControlE", 32'(ALUControlE), 32'd1);
      InstrD = 32'h010000EF; tick();
      check("jal_ImmExtE", ImmExtE, 32'h00000010);
      check("jal_ResultSrcE", 32'(ResultSrcE), 32'd2);

      InstrD = 32'h002081B3; setW(1'b1, 5'd1, 32'hDEADBEEF); tick();
      check("bypass_RD1E", RD1E, 32'hDEADBEEF);
      setW(1'b0, 5'd0, 32'd0); tick();
      check("x1_after_bypass", RD1E, 32'hDEADBEEF);

      InstrD = 32'h000001B3; setW(1'b1, 5'd0, 32'd5); tick();
      check("x0_same_edge", RD1E, 32'd0);
      setW(1'b0, 5'd0, 32'd0); tick();
      check("x0_after_write", RD1E, 32'd0);

      InstrD = 32'h002081B3; FlushE = 1'b1; setW(1'b1, 5'd4, 32'd9); tick();
      check("flush_RD1E", RD1E, 32'd0);
      check("flush_PCE", PCE, 32'd0);
      FlushE = 1'b0; setW(1'b0, 5'd0, 32'd0); InstrD = 32'h000201B3; tick();
      check("flush_x4_written", RD1E, 32'd9);

      for (int n = 0; n < 300; n++) begin
         r = $urandom();
         InstrD   = {r[31:7], ops[$urandom_range(6, 0)]};
         PCD      = $urandom() & 32'hFFFFFFFC;
         PCPlus4D = PCD + 32'd4;
         FlushE   = ($urandom_range(7, 0) == 0);
         RegWriteW = $urandom_range(1, 0) == 1;
         RDW      = ($urandom_range(3, 0) == 0) ? InstrD[19:15] : 5'($urandom());
         ResultW  = $urandom();
         tick();
      end

      FlushE = 1'b0; InstrD = 32'h002081B3;
      rst = 1'b0; setW(1'b1, 5'd6, 32'h1234); tick();
      check("midreset_RegWriteE", 32'(RegWriteE), 32'd0);
      rst = 1'b1; setW(1'b0, 5'd0, 32'd0); tick();
      check("resume_RegWriteE", 32'(RegWriteE), 32'd1);
      check("resume_RD1E", RD1E, 32'd0);
      for (int k = 1; k < 32; k++) begin
         r = 32'h33 | (32'(k) << 15) | (32'(k) << 20) | (32'd3 << 7);
         InstrD = r;
         tick();
         check("postreset_reg_zero", RD1E | RD2E, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
